magic_packet_injector: RTL and testbench

MAGIC_PACKET_INJECTOR -- requirements
Module: magic_packet_injector

---
 rtl/magic_packet_injector.sv | 122 ++++++++++++
 tb/tb_magic_packet_injector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/magic_packet_injector.sv
// Drives a filler stream, then one magic packet, into a FIFO under test, and drains it afterwards.
// Define LFSR_DATA_EN for a Galois LFSR filler generator; a plain counter is used otherwise.
module magic_packet_injector #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int CNTWID = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [CNTWID-1:0] pre_cnt,
  input  logic [WIDTH-1:0]  magic_data,
  input  logic              full,
  input  logic              empty,
  output logic              push,
  output logic              pop,
  output logic [WIDTH-1:0]  data_in,
  output logic              start,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FILL, MAGIC, DRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [CNTWID-1:0] cnt, pre_lat, cnt_inc;
  logic [WIDTH-1:0]  magic_lat, gen, gen_adv, gen_seed, filler;

`ifdef LFSR_DATA_EN
  // Right-shifting Galois tap masks giving maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      3:       return 32'h6;
      4:       return 32'hC;
      5:       return 32'h14;
      6:       return 32'h30;
      7:       return 32'h60;
      8:       return 32'hB8;
      16:      return 32'hB400;
      default: return 32'h0;
    endcase
  endfunction

  localparam logic [31:0]      TAPS32 = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS   = TAPS32[WIDTH-1:0];

  assign gen_seed = WIDTH'(1);
  assign gen_adv  = gen[0] ? ((gen >> 1) ^ TAPS) : (gen >> 1);
`else
  assign gen_seed = '0;
  assign gen_adv  = gen + WIDTH'(1);
`endif

  // A filler must never be mistaken for the magic packet downstream.
  assign filler  = (gen == magic_lat) ? ~gen : gen;
  assign cnt_inc = cnt + CNTWID'(1);
  assign busy    = (state != IDLE);

  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    data_in    = '0;
    case (state)
      IDLE: begin
        if (go) state_next = (pre_cnt != '0) ? FILL : MAGIC;
      end
      FILL: begin
        push    = ~full;
        data_in = filler;
        if (!full && cnt_inc == pre_lat) state_next = MAGIC;
      end
      MAGIC: begin
        push    = ~full;
        start   = ~full;
        data_in = magic_lat;
        if (!full) state_next = DRAIN;
      end
      DRAIN: begin
        pop = ~empty;
        if (empty) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pre_lat   <= '0;
      magic_lat <= '0;
      gen       <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (go) begin
            pre_lat   <= pre_cnt;
            magic_lat <= magic_data;
            cnt       <= '0;
            gen       <= gen_seed;
          end
        end
        FILL: begin
          if (!full) begin
            cnt <= cnt_inc;
            gen <= gen_adv;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_magic_packet_injector.sv
// Self-checking bench: a packet-list model plus a virtual FIFO predicts every output each cycle.
module tb_magic_packet_injector;
  localparam int DEPTH  = 8;
  localparam int WIDTH  = 8;
  localparam int CNTWID = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst, go, full, empty;
  logic [CNTWID-1:0] pre_cnt;
  logic [WIDTH-1:0]  magic_data, data_in;
  logic              push, pop, start, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  magic_packet_injector #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTWID(CNTWID)) dut (
    .clk(clk), .rst(rst), .go(go), .pre_cnt(pre_cnt), .magic_data(magic_data),
    .full(full), .empty(empty), .push(push), .pop(pop), .data_in(data_in),
    .start(start), .busy(busy), .done(done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_push"}, 32'(push), 0);
    checkOutput({tag, "_pop"}, 32'(pop), 0);
    checkOutput({tag, "_start"}, 32'(start), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_data"}, 32'(data_in), 0);
  endtask

  // One run: the expected push list is fillers 0,1,2,... (inverted on a clash with magic) then magic.
  task automatic applyStimulus(input int pre, input logic [WIDTH-1:0] magic, input int stall_pct,
                               input int stall_at, input bit go_noise, input bit rst_in_drain);
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] v;
    int idx = 0;
    int phase;
    int stalled = 0;
    bit fin = 1'b0;
    for (int i = 0; i < pre; i++) begin
      v = WIDTH'(i);
      if (v == magic) v = ~v;
      exp_q.push_back(v);
    end
    exp_q.push_back(magic);

    go = 1'b1; pre_cnt = CNTWID'(pre); magic_data = magic; full = 1'b0; empty = 1'b1;
    #1;
    checkOutput("launch_busy", 32'(busy), 0);
    checkOutput("launch_push", 32'(push), 0);
    @(posedge clk); #1;
    go = 1'b0;
    phase = 1;

    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      empty = (fifo_q.size() == 0);
      full  = (fifo_q.size() >= DEPTH) || (int'($urandom_range(99)) < stall_pct);
      if (phase == 1 && idx == stall_at && stalled < 2) begin
        full = 1'b1;
        stalled++;
      end
      if (go_noise && (phase == 1 || phase == 2)) begin
        go         = 1'($urandom_range(1));
        pre_cnt    = CNTWID'($urandom);
        magic_data = WIDTH'($urandom);
      end else begin
        go = 1'b0;
      end
      #1;
      case (phase)
        1: begin
          checkOutput("fill_push", 32'(push), 32'(!full));
          checkOutput("fill_start", 32'(start), 32'(!full && idx == exp_q.size() - 1));
          checkOutput("fill_pop", 32'(pop), 0);
          checkOutput("fill_data", 32'(data_in), 32'(exp_q[idx]));
          checkOutput("fill_busy", 32'(busy), 1);
          checkOutput("fill_done", 32'(done), 0);
        end
        2: begin
          if (rst_in_drain && !empty) begin
            rst = 1'b1; go = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; go = 1'b0; full = 1'b0; empty = 1'b1;
            #1;
            checkIdle("rst_drain");
            fin = 1'b1;
          end else begin
            checkOutput("drain_push", 32'(push), 0);
            checkOutput("drain_start", 32'(start), 0);
            checkOutput("drain_pop", 32'(pop), 32'(!empty));
            checkOutput("drain_busy", 32'(busy), 1);
            checkOutput("drain_done", 32'(done), 0);
          end
        end
        default: begin
          checkOutput("done_pulse", 32'(done), 1);
          checkOutput("done_busy", 32'(busy), 1);
          checkOutput("done_push", 32'(push), 0);
          checkOutput("done_pop", 32'(pop), 0);
          checkOutput("done_data", 32'(data_in), 0);
        end
      endcase
      if (!fin) begin
        @(posedge clk); #1;
        case (phase)
          1: begin
            if (!full) begin
              fifo_q.push_back(exp_q[idx]);
              idx++;
              if (idx == exp_q.size()) phase = 2;
            end
          end
          2: begin
            if (!empty) fifo_q.delete(0);
            else phase = 3;
          end
          default: begin
            go = 1'b0; full = 1'b0; empty = 1'b1;
            #1;
            checkIdle("post_done");
            fin = 1'b1;
          end
        endcase
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL run_timeout observed=unfinished expected=finished pre=%0d", pre);
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; full = 1'b0; empty = 1'b1; pre_cnt = '0; magic_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(3, 8'hA5, 0, -1, 1'b0, 1'b0);
    applyStimulus(0, 8'h3C, 0, -1, 1'b0, 1'b0);
    applyStimulus(3, 8'h5A, 0, 1, 1'b0, 1'b0);
    applyStimulus(3, 8'h01, 0, -1, 1'b0, 1'b0);
    applyStimulus(2, 8'h00, 0, -1, 1'b0, 1'b0);
    applyStimulus(DEPTH - 1, 8'h06, 0, -1, 1'b0, 1'b0);
    applyStimulus(5, 8'h77, 0, -1, 1'b1, 1'b1);
    applyStimulus(4, 8'h02, 0, -1, 1'b1, 1'b0);
    for (int r = 0; r < 30; r++) begin
      applyStimulus(int'($urandom_range(DEPTH - 1)), WIDTH'($urandom_range(7)), 30, -1,
                    1'b1, ($urandom_range(4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
